// File: rtl/sa_feed_sequencer.sv
// Feed sequencer for a cascade of systolic arrays: streams a job of 4-bit elements into the
// skew shift-chain, inserts zero bubbles when upstream stalls, then drains the chain.
module sa_feed_sequencer #(
  parameter int unsigned SA_NUM = 4,
  parameter int unsigned LEN_W  = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             src_valid,
  input  logic [3:0]       src_data,
  output logic             src_ready,
  output logic [3:0]       feed_data,
  output logic             feed_en,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] elem_cnt
);

  localparam int unsigned D         = (SA_NUM - 1) * 4;
  localparam int unsigned DrainLoad = (D > 0) ? D - 1 : 0;
  localparam int unsigned CntW      = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [CntW-1:0]  drain_q, drain_d;
  logic [3:0]       feed_data_q, feed_data_d;
  logic             feed_en_q, feed_en_d;
  logic             xfer;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    src_ready   = (state_q == StStream);
    xfer        = src_ready & src_valid;
    // Every non-transfer cycle pushes a zero bubble into the free-running chain.
    feed_en_d   = xfer;
    feed_data_d = xfer ? src_data : 4'd0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = '0;
          if (len != '0) begin
            len_d   = len;
            state_d = StStream;
          end else begin
            state_d = StDone;
          end
        end
      end
      StStream: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) begin
            state_d = StDrain;
            drain_d = CntW'(DrainLoad);
          end
        end
      end
      StDrain: begin
        if (drain_q == '0) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      drain_q     <= '0;
      feed_data_q <= 4'd0;
      feed_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      feed_data_q <= feed_data_d;
      feed_en_q   <= feed_en_d;
    end
  end

  assign feed_data = feed_data_q;
  assign feed_en   = feed_en_q;
  assign busy      = (state_q == StStream) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign elem_cnt  = cnt_q;

endmodule

// File: doc/sa_feed_sequencer.md
SA_FEED_SEQUENCER -- requirements
Module: sa_feed_sequencer

Interface
REQ-001 The block SHALL expose parameter SA_NUM, default 4: number of cascaded systolic arrays.
REQ-002 The block SHALL expose parameter LEN_W, default 8: width of the job length field.
REQ-003 The block SHALL define the derived drain depth D = (SA_NUM-1)*4, equal to the skew-chain depth (12 at default).
REQ-004 The block SHALL use the already decided clock and reset: reset rstn, asynchronous, active-low; clock clk.
REQ-005 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1, job request pulse, sampled only in IDLE.
REQ-008 The block SHALL have port len, input, LEN_W, number of 4-bit elements in the job, captured with start.
REQ-009 The block SHALL have port src_valid, input, 1, upstream element valid.
REQ-010 The block SHALL have port src_data, input, 4, upstream element.
REQ-011 The block SHALL have port src_ready, output, 1, upstream accept.
REQ-012 The block SHALL have port feed_data, output, 4, registered value driven into the skew shift-chain input.
REQ-013 The block SHALL have port feed_en, output, 1, registered; high when feed_data carries a real element.
REQ-014 The block SHALL have port busy, output, 1, high in STREAM and DRAIN.
REQ-015 The block SHALL have port done, output, 1, single-cycle completion pulse.
REQ-016 The block SHALL have port elem_cnt, output, LEN_W, number of elements accepted in the current job.

Function
REQ-017 The block SHALL implement the FSM states IDLE, STREAM, DRAIN and DONE.
REQ-018 In IDLE, start=1 with len!=0 SHALL capture len, clear elem_cnt and go to STREAM next cycle; start=1 with len==0 SHALL go directly to DONE.
REQ-019 In STREAM, src_ready SHALL be 1; a transfer occurs when src_valid and src_ready are both 1.
REQ-020 src_ready SHALL be 0 in every state other than STREAM.
REQ-021 A transfer in cycle t SHALL give feed_data=src_data and feed_en=1 in cycle t+1, and SHALL increment elem_cnt at the same edge.
REQ-022 Any cycle without a transfer SHALL give feed_data=0 and feed_en=0 in the next cycle, inserting a zero bubble into the free-running chain.
REQ-023 The transfer that makes elem_cnt equal the captured len SHALL move the FSM to DRAIN at the same edge; src_ready SHALL be 0 from the next cycle.
REQ-024 DRAIN SHALL last exactly D cycles, counted by an internal down-counter loaded with D-1, with feed_data=0 and feed_en=0 (apart from the final element registered on entry).
REQ-025 When the drain counter reaches 0, the FSM SHALL go to DONE.
REQ-026 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE.
REQ-027 start SHALL be ignored in STREAM, DRAIN and DONE, including a start coincident with done.
REQ-028 The captured len SHALL stay stable for the whole job; changes on the len input after capture SHALL have no effect.
REQ-029 elem_cnt SHALL hold its value through DRAIN and DONE, and SHALL clear only on the next accepted start.

Reset
REQ-030 rstn low SHALL immediately force state IDLE, feed_data=0, feed_en=0, src_ready=0, busy=0, done=0, elem_cnt=0 and drain counter=0, at any point including mid-STREAM or mid-DRAIN.
REQ-031 After rstn deassertion, the first start SHALL be honoured at the first rising edge.

Verification
REQ-032 Bench SHALL cover: reset asserted during STREAM with elem_cnt=2 -> all outputs 0 at once; next start accepted normally.
REQ-033 Bench SHALL cover: SA_NUM=4, start at edge 0, len=3, src_valid=1 with A,B,C -> transfers cycles 1-3; feed_data A,B,C cycles 2-4; DRAIN cycles 4-15; done=1 only in cycle 16.
REQ-034 Bench SHALL cover: len=3, src_valid pattern 1,0,1,1 -> feed_en 1,0,1,1 with feed_data 0 in the gap; elem_cnt=3; DRAIN entered after the 4th cycle.
REQ-035 Bench SHALL cover: len=0 start -> src_ready never 1, feed_en never 1, done=1 in cycle 1, busy stays 0.
REQ-036 Bench SHALL cover: start pulses during STREAM, DRAIN and in the done cycle -> ignored; only one done per job.
REQ-037 Bench SHALL cover: len=255 with random src_valid -> exactly 255 feed_en pulses, then exactly 12 DRAIN cycles, then one done.
